// File: rtl/weight_pingpong_buffer.sv
// Ping-pong weight buffer: packs PACK_RATIO narrow DDR beats into wide words in one bank
// while the other bank is replayed cfg_reuse times to the MAC array.
module weight_pingpong_buffer #(
    parameter int IN_WIDTH   = 256,
    parameter int PACK_RATIO = 4,
    parameter int DEPTH      = 256,
    parameter int REUSE_W    = 4,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_W:0]                cfg_words,
    input  logic [REUSE_W-1:0]             cfg_reuse,
    output logic [IN_WIDTH*PACK_RATIO-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           tile_done,
    output logic [1:0]                     bank_full
);
    localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO;
    localparam int PC_W      = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;

    // Word count 0 or above DEPTH means a full bank; returns the last word address.
    function automatic logic [ADDR_W-1:0] words_to_last(input logic [ADDR_W:0] w);
        logic [ADDR_W:0] t;
        if (w == '0 || w > (ADDR_W+1)'(DEPTH)) t = (ADDR_W+1)'(DEPTH - 1);
        else                                    t = w - 1'b1;
        return t[ADDR_W-1:0];
    endfunction

    // Reuse count 0 means a single pass; returns the last pass index.
    function automatic logic [REUSE_W-1:0] reuse_to_last(input logic [REUSE_W-1:0] r);
        return (r == '0) ? '0 : r - 1'b1;
    endfunction

    logic [OUT_WIDTH-1:0] mem [0:2*DEPTH-1];

    logic                 wr_bank, rd_bank;
    logic [ADDR_W-1:0]    wr_addr;
    logic [PC_W-1:0]      pack_cnt;
    logic [OUT_WIDTH-1:0] pack_buf, word_w;
    logic [ADDR_W-1:0]    desc_last [2];
    logic [REUSE_W-1:0]   desc_pass [2];
    logic                 accept, first_beat, word_wr, tile_wr;
    logic [ADDR_W-1:0]    cur_last;
    logic [1:0]           full_nxt;
    logic                 wr_bank_nxt;

    logic [ADDR_W-1:0]    iss_addr;
    logic [REUSE_W-1:0]   iss_pass;
    logic                 iss_done, issue, iss_is_last, iss_is_fin;
    logic [2:0]           occ;

    logic [OUT_WIDTH-1:0] rd_data_p1;
    logic                 last_p1, fin_p1, vld_p1;

    logic [OUT_WIDTH-1:0] ent_data [2];
    logic                 ent_last [2];
    logic                 ent_fin  [2];
    logic [1:0]           cnt;
    logic [1:0]           push_idx;
    logic                 pop;

    always_comb begin
        accept     = in_valid & in_ready;
        first_beat = (pack_cnt == '0) && (wr_addr == '0);
        word_w     = pack_buf;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (pack_cnt == PC_W'(k)) word_w[k*IN_WIDTH +: IN_WIDTH] = in_data;
        end
        word_wr  = accept && (pack_cnt == PC_W'(PACK_RATIO - 1));
        // The descriptor is not yet latched while the first beat is being accepted.
        cur_last = first_beat ? words_to_last(cfg_words) : desc_last[wr_bank];
        tile_wr  = word_wr && (wr_addr == cur_last);
    end

    always_comb begin
        pop         = (cnt != 2'd0) && out_ready;
        out_valid   = (cnt != 2'd0);
        out_data    = out_valid ? ent_data[0] : '0;
        out_last    = out_valid & ent_last[0];
        tile_done   = pop & ent_fin[0];
        iss_is_last = (iss_addr == desc_last[rd_bank]);
        iss_is_fin  = iss_is_last && (iss_pass == desc_pass[rd_bank]);
        // Reads in flight plus held words must never exceed the two skid entries.
        occ         = 3'(cnt) + 3'(vld_p1);
        issue       = bank_full[rd_bank] && !iss_done && ((occ - 3'(pop)) < 3'd2);
        push_idx    = cnt - {1'b0, pop};
        full_nxt    = bank_full;
        if (tile_wr)   full_nxt[wr_bank] = 1'b1;
        if (tile_done) full_nxt[rd_bank] = 1'b0;
        wr_bank_nxt = wr_bank ^ tile_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full    <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            in_ready     <= 1'b0;
            pack_cnt     <= '0;
            wr_addr      <= '0;
            desc_last[0] <= '0;
            desc_last[1] <= '0;
            desc_pass[0] <= '0;
            desc_pass[1] <= '0;
            iss_addr     <= '0;
            iss_pass     <= '0;
            iss_done     <= 1'b0;
            vld_p1       <= 1'b0;
            cnt          <= '0;
        end else begin
            bank_full <= full_nxt;
            wr_bank   <= wr_bank_nxt;
            in_ready  <= !full_nxt[wr_bank_nxt];
            if (accept) pack_cnt <= word_wr ? '0 : pack_cnt + 1'b1;
            if (word_wr) wr_addr <= tile_wr ? '0 : wr_addr + 1'b1;
            if (accept && first_beat) begin
                desc_last[wr_bank] <= words_to_last(cfg_words);
                desc_pass[wr_bank] <= reuse_to_last(cfg_reuse);
            end
            vld_p1 <= issue;
            if (issue) begin
                iss_addr <= iss_is_last ? '0 : iss_addr + 1'b1;
                if (iss_is_last) iss_pass <= iss_is_fin ? '0 : iss_pass + 1'b1;
                if (iss_is_fin)  iss_done <= 1'b1;
            end
            if (tile_done) begin
                iss_done <= 1'b0;
                rd_bank  <= ~rd_bank;
            end
            cnt <= cnt + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    // p0: pack beats and write banks; p1: registered bank read
    always_ff @(posedge clk) begin
        if (accept)  pack_buf <= word_w;
        if (word_wr) mem[{wr_bank, wr_addr}] <= word_w;
        if (issue) begin
            rd_data_p1 <= mem[{rd_bank, iss_addr}];
            last_p1    <= iss_is_last;
            fin_p1     <= iss_is_fin;
        end
    end

    // p2: two-entry skid, entry 0 drives the output
    always_ff @(posedge clk) begin
        if (pop) begin
            ent_data[0] <= ent_data[1];
            ent_last[0] <= ent_last[1];
            ent_fin[0]  <= ent_fin[1];
        end
        if (vld_p1) begin
            ent_data[push_idx[0]] <= rd_data_p1;
            ent_last[push_idx[0]] <= last_p1;
            ent_fin[push_idx[0]]  <= fin_p1;
        end
    end
endmodule

// File: doc/weight_pingpong_buffer.md
Name: weight_pingpong_buffer

Overview:
Parametrised ping-pong weight buffer that succeeds the fixed 256-to-324/1296 weight memory path. A narrow DDR-side stream is packed PACK_RATIO:1 into wide channel words and written into one of two banks while the other bank is streamed to the MAC array. Per-tile word count and reuse (replay) count are configurable, so one tile of weights can feed several output passes without refetching from DDR. Single clock domain.

Parameters:
IN_WIDTH, 256, DDR-side beat width (bits)
PACK_RATIO, 4, input beats per output word; OUT_WIDTH = IN_WIDTH*PACK_RATIO
DEPTH, 256, output words per bank (power of 2, >=2)
REUSE_W, 4, width of reuse-count field
ADDR_W, clog2(DEPTH), derived bank address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_data  in  IN_WIDTH  packed weight beat; beat k of a word lands at bits [k*IN_WIDTH +: IN_WIDTH], k=0 first
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&in_ready
cfg_words  in  ADDR_W+1  output words per tile; 0 treated as DEPTH, values >DEPTH clamp to DEPTH
cfg_reuse  in  REUSE_W  passes per tile; 0 treated as 1
out_data  out  OUT_WIDTH  channel weight word
out_valid  out  1  word valid
out_ready  in  1  consumer accepts when out_valid&out_ready
out_last  out  1  high with last word of each pass
tile_done  out  1  one-cycle pulse when the final word of the final pass is accepted
bank_full  out  2  per-bank full flags

Behaviour:
- Reset (rst=1 at posedge): both banks empty, wr_bank=rd_bank=0, pack counter/address/pass counters 0; in_ready=0, out_valid=0, out_last=0, tile_done=0, bank_full=0, out_data=0. in_ready rises the first cycle after rst deasserts. Reset mid-transfer discards partial words and all stored tiles.
- Write side: in_ready = !bank_full[wr_bank] (registered). cfg_words/cfg_reuse latched into the write bank's descriptor on the first accepted beat of a tile; changes mid-tile ignored.
- Pack counter 0..PACK_RATIO-1; on beat PACK_RATIO-1 the assembled word is written at wr_addr, wr_addr increments. When word cfg_words-1 is written: bank_full[wr_bank] set, wr_bank toggles, wr_addr=0. If the other bank is still full, in_ready drops the next cycle.
- Read side: when bank_full[rd_bank]=1, stream addresses 0..cfg_words-1, repeated cfg_reuse times. Memory read latency 1 cycle; first out_valid no later than 2 cycles after bank_full[rd_bank] rises. Sustained throughput 1 word/cycle with out_ready held high (internal 2-entry skid or equivalent; no bubbles between passes or words).
- AXI-style hold: once out_valid=1, out_data/out_last stable until accepted; out_valid never drops without acceptance.
- out_last=1 on word cfg_words-1 of every pass. On acceptance of the final word of the final pass: tile_done pulses, bank_full[rd_bank] cleared, rd_bank toggles.
- Simultaneous free and fill: bank cleared by reader in cycle N is writable (in_ready=1) at N+1; writer setting full and reader clearing the other bank in the same cycle both take effect.
- cfg_words=1: every word is out_last; cfg_reuse=1 with cfg_words=1 gives out_last and tile_done on the same word.
- Bank order strictly alternates; tiles are never reordered or skipped.

Test Plan:
(bench: IN_WIDTH=8, PACK_RATIO=4, DEPTH=16)
1. Reset, then feed 16 beats 0x00..0x0F, cfg_words=4, cfg_reuse=1, out_ready=1 -> out_data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; out_last on 4th; tile_done once; bank_full returns 00.
2. cfg_words=3, cfg_reuse=3, 12 beats -> 9 words, sequence of 3 words repeated 3x, out_last on words 3/6/9, tile_done only on 9th.
3. out_ready=0, push 3 tiles of cfg_words=16 -> bank_full=11 after 128 beats, in_ready=0, beat 129 stalls; raise out_ready -> in_ready=1 one cycle after first tile_done, tile order 1,2,3 preserved.
4. Random out_ready toggling (50%) over cfg_words=16, cfg_reuse=2 -> all 32 words correct, out_data stable while out_valid&!out_ready, zero loss/duplication.
5. Assert rst after 6 beats of a tile and after 2 words read of another -> next cycle all outputs 0, bank_full=00; fresh tile reads back correctly from word 0.
6. cfg_words=0, cfg_reuse=0 -> treated as 16 words, 1 pass; out_last on word 16, tile_done once; throughput 16 words in 16 consecutive cycles with out_ready=1.
